snn_seq_ctrl: RTL and testbench
===============================

Name: snn_seq_ctrl

Overview:
Top-level sequencer for the digit-recognition datapath. It streams 784 pixel bytes from the UART receiver into the input-layer RAM, then starts the SNN core and owns the RAM address mux while the core runs. On core completion it latches the digit, drives the LEDs and sends the ASCII result over the UART transmitter. It sits between uart_rx, the input RAM, snn_core and uart_tx, and replaces the ad-hoc control logic in the top level.

Parameters:
NUM_PIXELS, 784, bytes per image (28x28).
ADDR_W, 10, input RAM address width; must satisfy 2**ADDR_W >= NUM_PIXELS.
TIMEOUT_CYC, 50000000, inter-byte timeout in clk cycles (1 s at 50 MHz); used only with the optional feature.

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
rx_rdy  in  1  single-cycle pulse from uart_rx: rx_data is valid
rx_data  in  8  received pixel byte
ram_we  out  1  input RAM write enable
ram_addr  out  ADDR_W  input RAM address
ram_wdata  out  8  input RAM write data
core_addr  in  ADDR_W  read address requested by snn_core
core_start  out  1  single-cycle start pulse to snn_core
core_done  in  1  snn_core completion, sampled as a level
core_digit  in  4  classified digit, valid while core_done=1
tx_start  out  1  single-cycle pulse to uart_tx
tx_data  out  8  byte to transmit
tx_rdy  in  1  uart_tx idle/ready
led  out  8  LED drive
busy  out  1  high in every state except IDLE
rx_drop  out  1  pulse: a byte arrived while not loading and was discarded
timeout_err  out  1  pulse: load aborted by timeout; tied to 0 without the optional feature

Behaviour:
- Reset values: all pulse outputs 0, ram_we 0, ram_addr 0, ram_wdata 0, led 8'h00, tx_data 8'h00, busy 0, state IDLE, pixel_cnt 0, digit_q 0.
- States: IDLE, LOAD, START, RUN, TX, TX_WAIT.
- IDLE: on rx_rdy, write rx_data to address 0 (combinational ram_we=1, ram_wdata=rx_data, same cycle), set pixel_cnt=1, go to LOAD.
- LOAD: on rx_rdy, write to ram_addr=pixel_cnt and increment pixel_cnt. The write at address NUM_PIXELS-1 moves the FSM to START and clears pixel_cnt to 0. No write occurs without rx_rdy.
- START: assert core_start for exactly one cycle, then go to RUN.
- RUN: wait for core_done=1. On that cycle, latch core_digit into digit_q, set led<={4'h0,core_digit} (registered, visible the next cycle), go to TX.
- TX: when tx_rdy=1, pulse tx_start and go to TX_WAIT.
  - tx_data is 8'h30+digit_q if digit_q<=9, else 8'h3F ('?').
  - tx_data is held stable from TX entry through TX_WAIT exit.
- TX_WAIT: ignore tx_rdy on the first cycle (guard flop). Afterwards return to IDLE when tx_rdy=1.
- Address mux: ram_addr=pixel_cnt in IDLE and LOAD; ram_addr=core_addr in START, RUN, TX and TX_WAIT.
- ram_we is 0 outside IDLE and LOAD.
- rx_rdy in START, RUN, TX or TX_WAIT: byte discarded, rx_drop pulses in the same cycle, no state change.
- led holds its value until the next core_done. It is unaffected by a new load.
- Asynchronous reset at any point (mid-load, mid-run, mid-TX) returns to IDLE with the reset values above. A partially loaded image is abandoned and the next byte is pixel 0.

Optional Feature:
Macro: PIXEL_TIMEOUT_EN.
- Defined: an idle counter runs in LOAD. It clears on every rx_rdy and increments otherwise. When it reaches TIMEOUT_CYC-1, the FSM:
  - pulses timeout_err for one cycle,
  - clears pixel_cnt to 0,
  - returns to IDLE, so the next byte is treated as pixel 0.
  - The counter width is $clog2(TIMEOUT_CYC).
- Not defined: no counter is built, LOAD waits indefinitely, and timeout_err is constant 0.

Test Plan:
- Reset, then 784 rx_rdy pulses carrying values i[7:0]. Expect:
  - 784 writes, addresses 0..783 with matching data;
  - one core_start pulse, the cycle after the final write;
  - ram_addr following core_addr from START onward.
- After the load, drive core_done with core_digit=7. Expect led=8'h07, tx_data=8'h37, one tx_start pulse, and a return to IDLE after tx_rdy rises again.
- Hold tx_rdy=0 for 100 cycles after core_done with digit 3. Expect tx_start delayed until tx_rdy=1, tx_data=8'h33 held stable, and no duplicate tx_start.
- Send 5 rx_rdy pulses during RUN. Expect 5 rx_drop pulses, no ram_we, and state unchanged.
- Assert rst_n=0 after 400 bytes, release, then load 784 bytes. Expect addresses to restart at 0 and exactly one core_start.
- With PIXEL_TIMEOUT_EN and TIMEOUT_CYC=1000, send 10 bytes then stall 1000 cycles. Expect one timeout_err pulse, a return to IDLE, and the next byte written at address 0.

Source files
------------

// File: rtl/snn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// snn_seq_ctrl - top-level sequencer for the digit-recognition datapath.
//
// Flow: stream NUM_PIXELS bytes from uart_rx into the input RAM, pulse
// core_start, hand the RAM address to snn_core while it runs, then latch the
// classified digit onto the LEDs and send it as ASCII through uart_tx.
//
// Optional feature macro: PIXEL_TIMEOUT_EN
//   Defined   : LOAD aborts after TIMEOUT_CYC idle cycles between bytes
//               (timeout_err pulses, next byte is pixel 0).
//   Undefined : LOAD waits indefinitely, timeout_err is constant 0.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rx_rdy, rx_data          byte strobe / byte from uart_rx
//   ram_we, ram_addr,        input RAM write port; ram_addr is muxed to
//   ram_wdata                core_addr once the image is loaded
//   core_addr                snn_core read address
//   core_start               one-cycle start pulse to snn_core
//   core_done, core_digit    completion level and classified digit
//   tx_start, tx_data,       uart_tx start pulse, byte, ready level
//   tx_rdy
//   led                      {4'h0, last digit}
//   busy                     high in every state except IDLE
//   rx_drop                  byte discarded because no load was possible
//   timeout_err              load aborted by inter-byte timeout
// -----------------------------------------------------------------------------
module snn_seq_ctrl #(
    parameter int NUM_PIXELS  = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    output logic [7:0]        led,
    output logic              busy,
    output logic              rx_drop,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_TX,
        S_TX_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    generate
        if ((2 ** ADDR_W) < NUM_PIXELS || TIMEOUT_CYC < 2) begin : g_bad_cfg
            $error("snn_seq_ctrl: ADDR_W too small for NUM_PIXELS or TIMEOUT_CYC < 2");
        end
    endgenerate

    state_t            state_reg;
    logic [ADDR_W-1:0] pixel_cnt_reg;
    logic [3:0]        digit_q_reg;
    logic [7:0]        tx_data_reg;
    logic              core_start_reg;
    logic              tx_start_reg;
    logic              tx_guard_reg;
    logic              loading;
    logic              timeout_hit;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // The RAM belongs to the loader in IDLE/LOAD and to snn_core otherwise.
    assign loading     = (state_reg == S_IDLE) || (state_reg == S_LOAD);
    assign ram_we      = loading && rx_rdy;
    assign ram_wdata   = ram_we ? rx_data : 8'h00;
    assign ram_addr    = loading ? pixel_cnt_reg : core_addr;
    assign rx_drop     = rx_rdy && !loading;
    assign busy        = (state_reg != S_IDLE);
    assign core_start  = core_start_reg;
    assign tx_start    = tx_start_reg;
    assign tx_data     = tx_data_reg;
    assign led         = {4'h0, digit_q_reg};

`ifdef PIXEL_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [IDLE_W-1:0] idle_cnt_reg;
    logic              timeout_err_reg;

    // A byte arriving on the terminal count still wins over the timeout.
    assign timeout_hit = (state_reg == S_LOAD) && !rx_rdy &&
                         (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= timeout_hit;
            if (state_reg != S_LOAD || rx_rdy || timeout_hit) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            pixel_cnt_reg  <= '0;
            digit_q_reg    <= 4'h0;
            tx_data_reg    <= 8'h00;
            core_start_reg <= 1'b0;
            tx_start_reg   <= 1'b0;
            tx_guard_reg   <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            tx_start_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (rx_rdy) begin
                        pixel_cnt_reg <= ADDR_W'(1);
                        state_reg     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (rx_rdy) begin
                        if (pixel_cnt_reg == LAST_ADDR) begin
                            pixel_cnt_reg  <= '0;
                            core_start_reg <= 1'b1;
                            state_reg      <= S_START;
                        end else begin
                            pixel_cnt_reg <= pixel_cnt_reg + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        pixel_cnt_reg <= '0;
                        state_reg     <= S_IDLE;
                    end
                end
                S_START: begin
                    state_reg <= S_RUN;
                end
                S_RUN: begin
                    if (core_done) begin
                        digit_q_reg <= core_digit;
                        tx_data_reg <= digit_ascii(core_digit);
                        state_reg   <= S_TX;
                    end
                end
                S_TX: begin
                    if (tx_rdy) begin
                        tx_start_reg <= 1'b1;
                        tx_guard_reg <= 1'b1;
                        state_reg    <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // uart_tx has not dropped tx_rdy yet on the first cycle.
                    if (tx_guard_reg) begin
                        tx_guard_reg <= 1'b0;
                    end else if (tx_rdy) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_seq_ctrl - self-checking bench for snn_seq_ctrl.
// Expected values come from a simple image/transaction model: the pixel array
// sent, the digit given to core_done, and the ASCII rule for tx_data.
// -----------------------------------------------------------------------------
module tb_snn_seq_ctrl;

    localparam int NPIX       = 784;
    localparam int AW         = 10;
    localparam int TB_TIMEOUT = 1000;
    localparam int LOG_N      = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [AW-1:0] core_addr = '0;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [3:0]    core_digit = 4'h0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_rdy = 1'b1;
    logic [7:0]    led;
    logic          busy;
    logic          rx_drop;
    logic          timeout_err;

    snn_seq_ctrl #(
        .NUM_PIXELS (NPIX),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .core_addr  (core_addr),
        .core_start (core_start),
        .core_done  (core_done),
        .core_digit (core_digit),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_rdy     (tx_rdy),
        .led        (led),
        .busy       (busy),
        .rx_drop    (rx_drop),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Passive event log, sampled on the active edge.
    int            n_wr = 0, n_cs = 0, n_ts = 0, n_drop = 0, n_to = 0;
    logic [AW-1:0] wr_addr_log [0:LOG_N-1];
    logic [7:0]    wr_data_log [0:LOG_N-1];

    always @(posedge clk) begin
        if (ram_we) begin
            wr_addr_log[n_wr % LOG_N] <= ram_addr;
            wr_data_log[n_wr % LOG_N] <= ram_wdata;
            n_wr <= n_wr + 1;
        end
        if (core_start === 1'b1)  n_cs   <= n_cs + 1;
        if (tx_start === 1'b1)    n_ts   <= n_ts + 1;
        if (rx_drop === 1'b1)     n_drop <= n_drop + 1;
        if (timeout_err === 1'b1) n_to   <= n_to + 1;
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] img [0:NPIX-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_rdy  = 1'b1;
        rx_data = v;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
        rx_data = $urandom;
    endtask

    task automatic load(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            cyc($urandom_range(0, 2));
            send_byte(img[i]);
        end
    endtask

    task automatic check_writes(input string tag, input int base, input int first, input int count);
        int bad;
        int idx;
        bad = 0;
        for (int k = 0; k < count; k++) begin
            idx = (base + k) % LOG_N;
            if (wr_addr_log[idx] !== AW'(first + k) || wr_data_log[idx] !== img[first + k]) bad++;
        end
        check({tag, "_count"}, n_wr - base, count);
        check({tag, "_bad"}, bad, 0);
    endtask

    task automatic rand_image();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    endtask

    // Result phase: core_done with digit d, uart_tx held not-ready for hold cycles.
    task automatic result(input logic [3:0] d, input int hold);
        logic [7:0] exp;
        int         base_ts;
        int         tmo;
        int         bad;
        exp     = (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
        base_ts = n_ts;
        tx_rdy  = (hold == 0);
        core_digit = d;
        core_done  = 1'b1;
        cyc(1);
        core_done  = 1'b0;
        core_digit = 4'($urandom);
        check("led_after_done", led, {4'h0, d});
        check("tx_data_entry", tx_data, exp);
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                if (tx_start !== 1'b0 || tx_data !== exp || busy !== 1'b1) bad++;
                cyc(1);
            end
            check("tx_hold_stable", bad, 0);
            check("tx_hold_no_start", n_ts - base_ts, 0);
            tx_rdy = 1'b1;
        end
        tmo = 0;
        while (tx_start !== 1'b1 && tmo < 5) begin
            cyc(1);
            tmo++;
        end
        check("tx_start_seen", tx_start, 1);
        check("tx_data_at_start", tx_data, exp);
        tx_rdy = 1'b0;
        bad = 0;
        repeat (10) begin
            cyc(1);
            if (busy !== 1'b1 || tx_data !== exp || tx_start !== 1'b0) bad++;
        end
        check("tx_wait_stable", bad, 0);
        tx_rdy = 1'b1;
        tmo = 0;
        while (busy !== 1'b0 && tmo < 5) begin
            cyc(1);
            tmo++;
        end
        check("return_idle", busy, 0);
        check("tx_start_once", n_ts - base_ts, 1);
        check("led_hold", led, {4'h0, d});
    endtask

    initial begin
        int base_wr, base_cs, base_drop, bad, tmo;

        // Reset values.
        cyc(3);
        check("reset_busy", busy, 0);
        check("reset_led", led, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_ram_wdata", ram_wdata, 0);
        check("reset_pulses", {27'd0, core_start, tx_start, rx_drop, timeout_err, ram_we}, 0);
        rst_n = 1'b1;
        cyc(2);

        // Image 1: pixel i carries i[7:0].
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
        base_wr = n_wr;
        base_cs = n_cs;
        core_addr = AW'($urandom);
        load(0, NPIX);
        check("core_start_after_last", core_start, 1);
        check("start_busy", busy, 1);
        check("start_addr_mux", ram_addr, core_addr);
        cyc(1);
        check("core_start_single", core_start, 0);
        check_writes("img1_writes", base_wr, 0, NPIX);

        // RUN: address follows the core, stray bytes are dropped.
        for (int k = 0; k < 4; k++) begin
            core_addr = AW'($urandom);
            #1;
            check("run_addr_mux", ram_addr, core_addr);
            cyc(1);
        end
        base_drop = n_drop;
        base_wr   = n_wr;
        for (int k = 0; k < 5; k++) begin
            cyc($urandom_range(1, 3));
            rx_rdy  = 1'b1;
            rx_data = $urandom;
            #2;
            check("run_rx_drop", rx_drop, 1);
            check("run_no_we", ram_we, 0);
            @(posedge clk);
            #1;
            rx_rdy = 1'b0;
        end
        cyc(1);
        check("run_drop_count", n_drop - base_drop, 5);
        check("run_no_writes", n_wr - base_wr, 0);
        check("run_still_busy", busy, 1);
        check("img1_core_start_once", n_cs - base_cs, 1);
        result(4'd7, 0);

        // Reset in the middle of a load abandons the partial image.
        rand_image();
        load(0, 400);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_led", led, 0);
        check("async_rst_addr", ram_addr, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        rand_image();
        base_wr = n_wr;
        base_cs = n_cs;
        load(0, NPIX);
        cyc(2);
        check_writes("img2_writes", base_wr, 0, NPIX);
        check("img2_core_start_once", n_cs - base_cs, 1);
        result(4'd3, 100);

        // A new load leaves the LEDs alone; out-of-range digit gives '?'.
        rand_image();
        base_wr = n_wr;
        load(0, 300);
        check("led_during_load", led, 8'h03);
        load(300, NPIX - 300);
        cyc(2);
        check_writes("img3_writes", base_wr, 0, NPIX);
        result(4'($urandom_range(10, 15)), $urandom_range(1, 20));

        // Inter-byte stall.
        rand_image();
        base_wr = n_wr;
        load(0, 10);
`ifdef PIXEL_TIMEOUT_EN
        bad = 0;
        repeat (900) begin
            if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
            cyc(1);
        end
        check("timeout_not_early", bad, 0);
        tmo = 0;
        while (timeout_err !== 1'b1 && tmo < 200) begin
            cyc(1);
            tmo++;
        end
        check("timeout_err_pulse", timeout_err, 1);
        check("timeout_idle", busy, 0);
        cyc(1);
        check("timeout_err_single", timeout_err, 0);
        rand_image();
        base_wr = n_wr;
        load(0, NPIX);
        cyc(2);
        check_writes("after_timeout_writes", base_wr, 0, NPIX);
`else
        bad = 0;
        tmo = 0;
        repeat (1200) begin
            if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
            cyc(1);
        end
        check("stall_no_timeout", bad, 0);
        load(10, NPIX - 10);
        cyc(2);
        check_writes("stall_writes", base_wr, 0, NPIX);
`endif
        result(4'($urandom_range(0, 9)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
